calc_entry_ctrl: RTL and testbench
==================================

Name: calc_entry_ctrl

Overview:
- Consumer end of the keypad decode interface: takes `is_number`, `is_op`, `is_eq`, `any_btn`, `num_val` and `op_val` from the keypad scanner/decoder.
- Debounces and one-shots each key press, then runs the calculator entry state machine: operand A, operator, operand B, result.
- Drives the signed value shown by the display driver.
- Sits between the keypad decoder and the 7-segment/display block.

Parameters:
- NDIG, 3, max decimal digits per operand; operand range 0..10^NDIG-1.
- W, 12, signed width of operands, accumulator and `disp_val`; must hold ±2·(10^NDIG-1).
- STABLE, 4, consecutive cycles `any_btn` must hold a level before a press or release is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- any_btn  in  1  raw key-down indication from the decoder.
- is_number  in  1  decoded key is a digit.
- is_op  in  1  decoded key is an operator.
- is_eq  in  1  decoded key is equals.
- num_val  in  4  digit value 0..9.
- op_val  in  2  1 = plus, 2 = minus, 3 = multiply (optional feature), 0 = none.
- disp_val  out  W  signed value to display.
- err  out  1  overflow indication.
- key_evt  out  1  one-cycle pulse per accepted key.
- state  out  2  0 = A_ENTRY, 1 = OP_WAIT, 2 = B_ENTRY, 3 = RESULT.

Behaviour:
- Reset (reset = 0, async):
  - A, B, `disp_val`, digit count, stored op, `err`, `key_evt` all 0.
  - State A_ENTRY; debouncer disarmed-released.
- Debounce / one-shot:
  - Stable counter counts cycles `any_btn` equals its armed-opposite level.
  - After STABLE cycles high while released: sample the decoded inputs, issue one event, mark pressed.
  - After STABLE cycles low while pressed: mark released.
  - Any glitch shorter than STABLE restarts the count.
  - Held key produces exactly one event.
- Event decode, priority eq > op > number:
  - An op event with `op_val` = 0, or with `op_val` = 3 when the optional feature is off, is no event.
  - All decoded flags 0 (unmapped key) is no event; `key_evt` does not pulse.
  - `key_evt` pulses in the cycle after sampling, only for events that are not discarded.
- Transitions (all registered; `disp_val` updates with `key_evt`):
  - A_ENTRY, digit: if count < NDIG then A = A·10 + d, count++; digits beyond NDIG are ignored. disp = A.
  - A_ENTRY, op: store op, go OP_WAIT, disp = A. Zero digits entered means A = 0.
  - A_ENTRY, eq: go RESULT, R = A.
  - OP_WAIT, digit: B = d, count = 1, go B_ENTRY, disp = B.
  - OP_WAIT, op: replace stored op, stay.
  - OP_WAIT, eq: go RESULT, R = A.
  - B_ENTRY, digit: accumulate as in A_ENTRY.
  - B_ENTRY, op: A = A op B, store new op, go OP_WAIT, disp = A (chaining).
  - B_ENTRY, eq: R = A op B, go RESULT, disp = R.
  - RESULT, digit: clear err, A = d, count = 1, go A_ENTRY.
  - RESULT, op: if err = 0, A = R, store op, go OP_WAIT; if err = 1, ignored.
  - RESULT, eq: ignored.
- Overflow:
  - Any computed value with |value| > 10^NDIG-1 sets `err` = 1, forces disp = 0, goes RESULT.
  - `err` holds until the next digit event.
- Arithmetic:
  - Two's complement in W bits. A may be negative after chaining.
  - Entry digits are always non-negative.
- Reset mid-press: debouncer restarts released; a key still held after reset yields one event once stable.

Optional Feature:
- CALC_MULT_EN defined:
  - `op_val` = 3 is multiply.
  - Product formed in 2W bits, then range-checked as in Overflow.
  - Result truncated to W bits only when in range.
- Not defined:
  - `op_val` = 3 events are discarded and no multiplier is built.

Test Plan:
- Debounce: STABLE = 4; press bounces `any_btn` 1,0,1 for 2 cycles each, then holds 20 cycles with digit 7 → exactly one `key_evt`; disp = 7; state 0.
- Entry: keys 1,2,3,4 → disp = 123 (4th digit ignored); then `+` → state 1, disp = 123.
- Sum: keys 1,2,+,3,0,= → disp = 42, state 3, err = 0.
- Chaining and negative result: keys 5,-,9,+,1,= → after `+` disp = -4; final disp = -3.
- Overflow: keys 9,9,9,+,9,9,9,= → err = 1, disp = 0. Then digit 4 → err = 0, disp = 4, state 0.
- Reset mid-entry: keys 8,+,6, assert reset low for 1 cycle → disp = 0, state 0, err = 0. With CALC_MULT_EN: keys 1,2,*,1,2,= → disp = 144; without CALC_MULT_EN the `*` produces no `key_evt`.

Source files
------------

// File: rtl/calc_entry_ctrl.sv
// Calculator entry controller: debounced one-shot key events drive an A/op/B/result FSM.
// Optional `define CALC_MULT_EN enables op_val=3 as multiply.
module calc_entry_ctrl #(
  parameter int NDIG   = 3,
  parameter int W      = 12,
  parameter int STABLE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                any_btn,
  input  logic                is_number,
  input  logic                is_op,
  input  logic                is_eq,
  input  logic [3:0]          num_val,
  input  logic [1:0]          op_val,
  output logic signed [W-1:0] disp_val,
  output logic                err,
  output logic                key_evt,
  output logic [1:0]          state
);
  typedef enum logic [1:0] {A_ENTRY, OP_WAIT, B_ENTRY, RESULT} st_t;

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int MAXV = pow10(NDIG) - 1;
  localparam int SW   = $clog2(STABLE + 1);
  localparam int DW   = $clog2(NDIG + 1);
  localparam logic signed [2*W-1:0] L_MAX = (2*W)'(MAXV);
  localparam logic signed [2*W-1:0] L_MIN = -L_MAX;
  localparam logic signed [W-1:0]   TEN   = W'(10);

  logic          r_pressed;
  logic [SW-1:0] r_stb;
  st_t           r_state;
  logic signed [W-1:0] r_a, r_b, r_r;
  logic [DW-1:0] r_cnt;
  logic [1:0]    r_op;

  logic w_opp, w_fire, w_eq, w_op, w_num, w_evt, w_op_ok, w_ovf;
  logic signed [W-1:0]   w_dig, w_acc_a, w_acc_b, w_res;
  logic signed [2*W-1:0] w_a2, w_b2, w_res2;

  // Count consecutive cycles at the level opposite to the current debounced state.
  assign w_opp  = (any_btn != r_pressed);
  assign w_fire = w_opp && (r_stb == SW'(STABLE - 1)) && !r_pressed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pressed <= 1'b0;
      r_stb     <= '0;
    end else if (!w_opp) begin
      r_stb <= '0;
    end else if (r_stb == SW'(STABLE - 1)) begin
      r_stb     <= '0;
      r_pressed <= ~r_pressed;
    end else begin
      r_stb <= r_stb + SW'(1);
    end
  end

`ifdef CALC_MULT_EN
  assign w_op_ok = (op_val != 2'd0);
`else
  assign w_op_ok = (op_val != 2'd0) && (op_val != 2'd3);
`endif

  assign w_eq  = is_eq;
  assign w_op  = !is_eq && is_op && w_op_ok;
  assign w_num = !is_eq && !is_op && is_number;
  assign w_evt = w_eq || w_op || w_num;

  assign w_dig   = $signed({{(W-4){1'b0}}, num_val});
  assign w_acc_a = r_a * TEN + w_dig;
  assign w_acc_b = r_b * TEN + w_dig;

  always_comb begin
    w_a2 = {{W{r_a[W-1]}}, r_a};
    w_b2 = {{W{r_b[W-1]}}, r_b};
    case (r_op)
      2'd2:    w_res2 = w_a2 - w_b2;
`ifdef CALC_MULT_EN
      2'd3:    w_res2 = w_a2 * w_b2;
`endif
      default: w_res2 = w_a2 + w_b2;
    endcase
  end

  assign w_ovf = (w_res2 > L_MAX) || (w_res2 < L_MIN);
  assign w_res = w_res2[W-1:0];
  assign state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= A_ENTRY;
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_op     <= 2'd0;
      disp_val <= '0;
      err      <= 1'b0;
      key_evt  <= 1'b0;
    end else begin
      key_evt <= 1'b0;
      if (w_fire && w_evt) begin
        key_evt <= 1'b1;
        case (r_state)
          A_ENTRY: begin
            if (w_num) begin
              if (r_cnt < DW'(NDIG)) begin
                r_a      <= w_acc_a;
                r_cnt    <= r_cnt + DW'(1);
                disp_val <= w_acc_a;
              end
            end else if (w_op) begin
              r_op     <= op_val;
              r_state  <= OP_WAIT;
              disp_val <= r_a;
            end else begin
              r_r      <= r_a;
              r_state  <= RESULT;
              disp_val <= r_a;
            end
          end
          OP_WAIT: begin
            if (w_num) begin
              r_b      <= w_dig;
              r_cnt    <= DW'(1);
              r_state  <= B_ENTRY;
              disp_val <= w_dig;
            end else if (w_op) begin
              r_op <= op_val;
            end else begin
              r_r      <= r_a;
              r_state  <= RESULT;
              disp_val <= r_a;
            end
          end
          B_ENTRY: begin
            if (w_num) begin
              if (r_cnt < DW'(NDIG)) begin
                r_b      <= w_acc_b;
                r_cnt    <= r_cnt + DW'(1);
                disp_val <= w_acc_b;
              end
            end else if (w_ovf) begin
              err      <= 1'b1;
              r_r      <= '0;
              disp_val <= '0;
              r_state  <= RESULT;
            end else if (w_op) begin
              r_a      <= w_res;
              r_op     <= op_val;
              r_state  <= OP_WAIT;
              disp_val <= w_res;
            end else begin
              r_r      <= w_res;
              r_state  <= RESULT;
              disp_val <= w_res;
            end
          end
          default: begin
            if (w_num) begin
              err      <= 1'b0;
              r_a      <= w_dig;
              r_cnt    <= DW'(1);
              r_state  <= A_ENTRY;
              disp_val <= w_dig;
            end else if (w_op && !err) begin
              r_a     <= r_r;
              r_op    <= op_val;
              r_state <= OP_WAIT;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: debounce, entry, arithmetic, chaining, overflow, reset.
module tb_calc_entry_ctrl;
  logic clk = 1'b0;
  logic reset, any_btn, is_number, is_op, is_eq;
  logic [3:0] num_val;
  logic [1:0] op_val;
  logic signed [11:0] disp_val;
  logic err, key_evt;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int n_evt = 0;
  int e0;

  calc_entry_ctrl #(.NDIG(3), .W(12), .STABLE(4)) dut (
    .clk(clk), .reset(reset), .any_btn(any_btn), .is_number(is_number),
    .is_op(is_op), .is_eq(is_eq), .num_val(num_val), .op_val(op_val),
    .disp_val(disp_val), .err(err), .key_evt(key_evt), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (key_evt === 1'b1) n_evt++;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 0..9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 unmapped, 15 op with op_val 0
  task automatic set_key(input int k);
    is_number = (k <= 9);
    is_op     = (k >= 10 && k <= 12) || (k == 15);
    is_eq     = (k == 13);
    num_val   = (k <= 9) ? 4'(k) : 4'd0;
    op_val    = (k == 10) ? 2'd1 : (k == 11) ? 2'd2 : (k == 12) ? 2'd3 : 2'd0;
  endtask

  task automatic clr_key();
    is_number = 0; is_op = 0; is_eq = 0; num_val = 0; op_val = 0;
  endtask

  task automatic key(input int k);
    @(negedge clk);
    set_key(k);
    any_btn = 1'b1;
    repeat (8) @(negedge clk);
    any_btn = 1'b0;
    clr_key();
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; any_btn = 1'b0;
    clr_key();
    repeat (3) @(negedge clk);
    chk("rst_disp", disp_val, 0);
    chk("rst_err", err, 0);
    chk("rst_evt", key_evt, 0);
    chk("rst_state", state, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // bouncing press of digit 7, then a long hold
    set_key(7);
    any_btn = 1; repeat (2) @(negedge clk);
    any_btn = 0; repeat (2) @(negedge clk);
    any_btn = 1; repeat (2) @(negedge clk);
    chk("bounce_noevt", n_evt, 0);
    repeat (20) @(negedge clk);
    any_btn = 0; clr_key();
    repeat (8) @(negedge clk);
    chk("bounce_one_evt", n_evt, 1);
    chk("bounce_disp", disp_val, 7);
    chk("bounce_state", state, 0);

    do_reset();
    key(1); key(2); key(3); key(4);
    chk("entry_disp", disp_val, 123);
    key(10);
    chk("entry_op_state", state, 1);
    chk("entry_op_disp", disp_val, 123);

    do_reset();
    key(1); key(2); key(10); key(3); key(0); key(13);
    chk("sum_disp", disp_val, 42);
    chk("sum_state", state, 3);
    chk("sum_err", err, 0);
    key(10); key(8); key(13);
    chk("result_cont", disp_val, 50);

    do_reset();
    key(5); key(11); key(9); key(10);
    chk("chain_disp", disp_val, -4);
    chk("chain_state", state, 1);
    key(1); key(13);
    chk("chain_final", disp_val, -3);

    do_reset();
    key(9); key(9); key(9); key(10); key(9); key(9); key(9); key(13);
    chk("ovf_err", err, 1);
    chk("ovf_disp", disp_val, 0);
    chk("ovf_state", state, 3);
    key(10);
    chk("ovf_op_ignored", state, 3);
    key(4);
    chk("ovf_clr_err", err, 0);
    chk("ovf_clr_disp", disp_val, 4);
    chk("ovf_clr_state", state, 0);

    do_reset();
    key(5); key(10); key(11); key(3); key(13);
    chk("op_replace", disp_val, 2);
    do_reset();
    key(7); key(10); key(13);
    chk("opwait_eq_disp", disp_val, 7);
    chk("opwait_eq_state", state, 3);

    do_reset();
    key(8); key(10); key(6);
    chk("mid_disp", disp_val, 6);
    chk("mid_state", state, 2);
    do_reset();
    chk("mid_rst_disp", disp_val, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_err", err, 0);

    e0 = n_evt;
    key(14);
    chk("unmapped_noevt", n_evt, e0);
    key(15);
    chk("op0_noevt", n_evt, e0);

    // reset while a key is held: one fresh event once stable again
    @(negedge clk);
    set_key(3); any_btn = 1;
    repeat (8) @(negedge clk);
    chk("held_disp", disp_val, 3);
    e0 = n_evt;
    reset = 0;
    @(negedge clk);
    chk("held_rst_disp", disp_val, 0);
    reset = 1;
    repeat (10) @(negedge clk);
    any_btn = 0; clr_key();
    repeat (8) @(negedge clk);
    chk("held_rst_evt", n_evt, e0 + 1);
    chk("held_rst_val", disp_val, 3);

    do_reset();
    key(1); key(2);
    e0 = n_evt;
    key(12);
`ifdef CALC_MULT_EN
    chk("mul_evt", n_evt, e0 + 1);
    chk("mul_state", state, 1);
    key(1); key(2); key(13);
    chk("mul_disp", disp_val, 144);
`else
    chk("mul_noevt", n_evt, e0);
    chk("mul_state", state, 0);
    key(1); key(2); key(13);
    chk("mul_off_disp", disp_val, 121);
`endif
    chk("mul_final_state", state, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
